muldiv_hilo: RTL and testbench

Execute-side unit downstream of the instruction decoder. It consumes the decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes and the rs/rt register operands, and owns the HI/LO registers. Multiply completes in a single cycle. Divide is a 32-iteration restoring sequencer, and the unit stalls the CPU's PC/register-file write path while a divide runs.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_hilo_div_core.sv | 71 +++++++
 rtl/muldiv_hilo.sv | 150 +++++++++++++++
 tb/tb_muldiv_hilo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Wide enough for any XLEN up to 64; users slice the low XLEN bits.
  localparam logic [63:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  typedef enum logic {
    OP_DIV,
    OP_DIVU
  } op_e;

endpackage

// File: rtl/muldiv_hilo_div_core.sv
// Unsigned restoring divider.
// It produces one quotient bit per step pulse. The final quotient/remainder is valid on the step at count XLEN-1.
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            valid
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] rem_shift;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quot_next;
  logic            fits;

  // The bit shifted out of rem_q is treated as the (XLEN+1)th bit of the partial remainder.
  always_comb begin
    rem_shift = {rem_q[XLEN-2:0], quot_q[XLEN-1]};
    fits      = rem_q[XLEN-1] | (rem_shift >= dvsr_q);
    rem_next  = fits ? (rem_shift - dvsr_q) : rem_shift;
    quot_next = {quot_q[XLEN-2:0], fits};

    quotient  = quot_next;
    remainder = rem_next;
    valid     = step && (cnt_q == LAST);

    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvsr_d = divisor;
      cnt_d  = '0;
    end else if (step) begin
      rem_d  = rem_next;
      quot_d = quot_next;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO owner for the execute stage.
// It provides a single-cycle multiply and a sequenced signed/unsigned divide that stalls the CPU while it runs.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mult_instrc,
  input  logic            multu_instrc,
  input  logic            div_instrc,
  input  logic            divu_instrc,
  input  logic            mthi_instrc,
  input  logic            mtlo_instrc,
  input  logic            mfhi_instrc,
  input  logic            mflo_instrc,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] rd_data
);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            div0_q, div0_d;

  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] dvd_in, dvs_in;
  logic [2*XLEN-1:0] ext_rs, ext_rt, product;
  logic [XLEN-1:0] core_quot, core_rem;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic            core_load, core_step, core_valid;

  div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .dividend (dvd_in),
    .divisor  (dvs_in),
    .quotient (core_quot),
    .remainder(core_rem),
    .valid    (core_valid)
  );

  // Both multiplies share one 2*XLEN multiplier; only the operand extension differs.
  always_comb begin
    rs_neg  = rs_data[XLEN-1];
    rt_neg  = rt_data[XLEN-1];
    dvd_in  = (div_instrc && rs_neg) ? -rs_data : rs_data;
    dvs_in  = (div_instrc && rt_neg) ? -rt_data : rt_data;
    ext_rs  = mult_instrc ? {{XLEN{rs_data[XLEN-1]}}, rs_data} : {{XLEN{1'b0}}, rs_data};
    ext_rt  = mult_instrc ? {{XLEN{rt_data[XLEN-1]}}, rt_data} : {{XLEN{1'b0}}, rt_data};
    product = ext_rs * ext_rt;

    if (div0_q) begin
      quot_fix = DIV0_QUOT[XLEN-1:0];
    end else if ((op_q == OP_DIV) && neg_quot_q) begin
      quot_fix = -core_quot;
    end else begin
      quot_fix = core_quot;
    end
    // For a zero divisor this restores the raw dividend, because the remainder is then |rs|.
    rem_fix = ((op_q == OP_DIV) && neg_rem_q) ? -core_rem : core_rem;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    stall      = 1'b0;
    core_load  = 1'b0;
    core_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_instrc || divu_instrc) begin
          stall      = 1'b1;
          core_load  = 1'b1;
          state_d    = DIV;
          op_d       = div_instrc ? OP_DIV : OP_DIVU;
          neg_quot_d = rs_neg ^ rt_neg;
          neg_rem_d  = rs_neg;
          div0_d     = (rt_data == '0);
        end else if (mult_instrc || multu_instrc) begin
          hi_d = product[2*XLEN-1:XLEN];
          lo_d = product[XLEN-1:0];
        end else if (mthi_instrc) begin
          hi_d = rs_data;
        end else if (mtlo_instrc) begin
          lo_d = rs_data;
        end
      end
      DIV: begin
        stall     = 1'b1;
        core_step = 1'b1;
        if (core_valid) begin
          hi_d    = rem_fix;
          lo_d    = quot_fix;
          state_d = DONE;
        end
      end
      // The divide is still in decode here, so its strobe must not restart the sequencer.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_DIV;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = mfhi_instrc ? hi_q : (mflo_instrc ? lo_q : '0);

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo.
// The driver pushes expected results from an arithmetic model; a negedge monitor checks each retired instruction.
module tb_muldiv_hilo;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic mult_instrc, multu_instrc, div_instrc, divu_instrc;
  logic mthi_instrc, mtlo_instrc, mfhi_instrc, mflo_instrc;
  logic [XLEN-1:0] rs_data, rt_data;
  logic stall;
  logic [XLEN-1:0] hi, lo, rd_data;

  muldiv_hilo #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .mult_instrc (mult_instrc),
    .multu_instrc(multu_instrc),
    .div_instrc  (div_instrc),
    .divu_instrc (divu_instrc),
    .mthi_instrc (mthi_instrc),
    .mtlo_instrc (mtlo_instrc),
    .mfhi_instrc (mfhi_instrc),
    .mflo_instrc (mflo_instrc),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    int          stalls;
    bit          chk_rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        pend;
  bit          pend_valid = 1'b0;
  bit          instr_active = 1'b0;
  int          stall_cnt = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          total = 0;
  int          bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  // Strobe mask bits: 0 div, 1 divu, 2 mult, 3 multu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
  task automatic modelOp(input logic [7:0] mask, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
    longint      sq, sr, sp;
    logic [63:0] up;
    e.rd     = mask[6] ? m_hi : (mask[7] ? m_lo : 32'h0);
    e.chk_rd = !(mask[0] || mask[1]);
    e.stalls = 0;
    if (mask[0] || mask[1]) begin
      e.stalls = 33;
      if (b == 32'h0) begin
        m_lo = 32'hFFFF_FFFF;
        m_hi = a;
      end else if (mask[0]) begin
        sq   = longint'($signed(a)) / longint'($signed(b));
        sr   = longint'($signed(a)) % longint'($signed(b));
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end else if (mask[2]) begin
      sp   = longint'($signed(a)) * longint'($signed(b));
      m_hi = sp[63:32];
      m_lo = sp[31:0];
    end else if (mask[3]) begin
      up   = {32'h0, a} * {32'h0, b};
      m_hi = up[63:32];
      m_lo = up[31:0];
    end else if (mask[4]) begin
      m_hi = a;
    end else if (mask[5]) begin
      m_lo = a;
    end
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] mask,
                               input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   done;
    @(posedge clk);
    #1;
    {mflo_instrc, mfhi_instrc, mtlo_instrc, mthi_instrc,
     multu_instrc, mult_instrc, divu_instrc, div_instrc} = mask;
    rs_data = a;
    rt_data = b;
    modelOp(mask, a, b, e);
    e.name = name;
    exp_q.push_back(e);
    stall_cnt    = 0;
    instr_active = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    {mflo_instrc, mfhi_instrc, mtlo_instrc, mthi_instrc,
     multu_instrc, mult_instrc, divu_instrc, div_instrc} = 8'h00;
    instr_active = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout: stall still high after 100 cycles, want low", name);
      exp_q.delete();
    end
  endtask

  // The instruction retires on the first stall-low cycle; its HI/LO writes show one cycle later.
  always @(negedge clk) begin
    if (pend_valid) begin
      checkOutput({pend.name, " hi"}, hi, pend.hi);
      checkOutput({pend.name, " lo"}, lo, pend.lo);
      pend_valid = 1'b0;
    end
    if (instr_active) begin
      if (stall) begin
        stall_cnt++;
      end else if (exp_q.size() > 0) begin
        pend = exp_q.pop_front();
        checkOutput({pend.name, " stall cycles"}, 32'(stall_cnt), 32'(pend.stalls));
        if (pend.chk_rd) checkOutput({pend.name, " rd_data"}, rd_data, pend.rd);
        pend_valid = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  mask;
    logic [31:0] a, b;
    rst = 1'b1;
    {mflo_instrc, mfhi_instrc, mtlo_instrc, mthi_instrc,
     multu_instrc, mult_instrc, divu_instrc, div_instrc} = 8'h00;
    rs_data = '0;
    rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    checkOutput("reset stall", {31'h0, stall}, 32'h0);
    checkOutput("reset rd_data", rd_data, 32'h0);

    applyStimulus("mult neg", 8'h04, 32'hFFFF_FFFE, 32'd3);
    applyStimulus("multu big", 8'h08, 32'hFFFF_FFFE, 32'd3);
    applyStimulus("divu 100/7", 8'h02, 32'd100, 32'd7);
    applyStimulus("div -7/2", 8'h01, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("div min/-1", 8'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("divu by zero", 8'h02, 32'h0000_1234, 32'h0);
    applyStimulus("div neg by zero", 8'h01, 32'hFFFF_0000, 32'h0);
    applyStimulus("div 7/-2", 8'h01, 32'd7, 32'hFFFF_FFFE);
    applyStimulus("mthi", 8'h10, 32'hA5A5_A5A5, 32'h0);
    applyStimulus("mtlo", 8'h20, 32'h5A5A_5A5A, 32'h0);
    applyStimulus("mfhi", 8'h40, 32'h0, 32'h0);
    applyStimulus("mflo", 8'h80, 32'h0, 32'h0);
    applyStimulus("prio div over all", 8'h3F, 32'hFFFF_FF9C, 32'd7);
    applyStimulus("prio mult over rest", 8'h3C, 32'h8000_0001, 32'hFFFF_FFFF);
    applyStimulus("prio mthi over mtlo", 8'h30, 32'hDEAD_BEEF, 32'h0);

    for (int i = 0; i < 40; i++) begin
      mask = 8'(1 << $urandom_range(0, 7));
      a    = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      applyStimulus("random op", mask, a, b);
    end

    applyStimulus("pre-reset mthi", 8'h10, 32'h1234_5678, 32'h0);
    applyStimulus("pre-reset mtlo", 8'h20, 32'h8765_4321, 32'h0);
    repeat (2) @(negedge clk);

    @(posedge clk);
    #1;
    div_instrc = 1'b1;
    rs_data    = 32'd1000;
    rt_data    = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    checkOutput("stall mid divide", {31'h0, stall}, 32'h1);
    rst        = 1'b1;
    div_instrc = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort stall", {31'h0, stall}, 32'h0);
    checkOutput("abort hi", hi, 32'h0);
    checkOutput("abort lo", lo, 32'h0);
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    checkOutput("abort no late write hi", hi, 32'h0);
    checkOutput("abort no late write lo", lo, 32'h0);

    applyStimulus("post-reset divu", 8'h02, 32'd12345, 32'd100);
    applyStimulus("post-reset mult", 8'h04, 32'h0001_0000, 32'hFFFF_0000);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
